// File: rtl/handshake_rx_sink.sv
// Four-phase bundled-data receiver: synchronizes the pipeline request, captures each
// word into a small FIFO and presents the FIFO head on a valid/ready interface.
module handshake_rx_sink #(
    parameter int WIDTH       = 4,
    parameter int DEPTH       = 4,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       req_in,
    input  logic [WIDTH-1:0]           data_in,
    output logic                       ack_out,
    output logic [WIDTH-1:0]           out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     fifo_level,
    output logic [CNT_W-1:0]           word_count,
    output logic                       dbg_state
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        ACKED = 1'b1
    } state_t;

    // Handshake protocol (clk side):
    //   push: IDLE, synchronized request high and FIFO not full -> word captured, ack raised.
    //   ack_out stays high until the synchronized request falls.
    //   pop : out_valid && out_ready at a rising edge removes the head word.
    //   out_data is meaningful only while out_valid is high (forced to zero when empty).

    state_t                 state_q;
    logic                   ack_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   req_s;

    logic [WIDTH-1:0]       mem_q [DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]          rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]          level_q, level_d;
    logic [CNT_W-1:0]       count_q, count_d;

    logic                   full;
    logic                   push;
    logic                   pop;

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], req_in};
        end
    end

    assign req_s = sync_q[SYNC_STAGES-1];

    // Full is judged on the level before any same-cycle pop.
    assign full = (level_q == LW'(DEPTH));
    assign push = (state_q == IDLE) && req_s && !full;
    assign pop  = (level_q != '0) && out_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            ack_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_s && !full) begin
                        state_q <= ACKED;
                        ack_q   <= 1'b1;
                    end
                end
                ACKED: begin
                    if (!req_s) begin
                        state_q <= IDLE;
                        ack_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    ack_q   <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = count_q + CNT_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        case ({push, pop})
            2'b10:   level_d = level_q + LW'(1);
            2'b01:   level_d = level_q - LW'(1);
            default: level_d = level_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: the pointers and level define what is visible.
    always_ff @(posedge clk) begin
        if (reset && push) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign ack_out    = ack_q;
    assign out_valid  = (level_q != '0);
    assign out_data   = out_valid ? mem_q[rd_ptr_q] : '0;
    assign fifo_level = level_q;
    assign word_count = count_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_handshake_rx_sink.sv
// Directed bench for handshake_rx_sink: exact handshake latency, FIFO ordering,
// backpressure, simultaneous push/pop, reset mid-handshake and counter wrap.
module tb_handshake_rx_sink;

    localparam int WIDTH = 4;
    localparam int DEPTH = 4;
    localparam int LW    = $clog2(DEPTH) + 1;
    localparam int CNT_W = 8;

    logic              clk;
    logic              reset;
    logic              req_in;
    logic [WIDTH-1:0]  data_in;
    logic              ack_out;
    logic [WIDTH-1:0]  out_data;
    logic              out_valid;
    logic              out_ready;
    logic [LW-1:0]     fifo_level;
    logic [CNT_W-1:0]  word_count;
    logic              dbg_state;

    int checks   = 0;
    int failures = 0;
    int ack_pulses = 0;
    logic ack_prev = 1'b0;
    logic [WIDTH-1:0] exp_q[$];

    handshake_rx_sink #(
        .WIDTH(WIDTH), .DEPTH(DEPTH), .SYNC_STAGES(2), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .reset(reset), .req_in(req_in), .data_in(data_in),
        .ack_out(ack_out), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_level(fifo_level),
        .word_count(word_count), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "simulation time limit");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: a pop happens at the next rising edge when valid&&ready hold mid-cycle.
    always @(negedge clk) begin
        if (ack_out && !ack_prev) ack_pulses++;
        ack_prev = ack_out;
        if (reset && out_valid && out_ready) begin
            check("pop_has_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) check("pop_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ack(input logic val, input string tag);
        for (int n = 0; n < 20 && ack_out !== val; n++) tick();
        check(tag, 32'(ack_out), 32'(val));
    endtask

    task automatic send_word(input logic [WIDTH-1:0] d);
        exp_q.push_back(d);
        data_in = d;
        req_in  = 1'b1;
        wait_ack(1'b1, "send_ack_high");
        req_in  = 1'b0;
        wait_ack(1'b0, "send_ack_low");
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int n = 0; n < 20 && out_valid; n++) tick();
        check("drain_level", 32'(fifo_level), 32'd0);
        out_ready = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int pulses0;
        reset = 1'b0; req_in = 1'b1; data_in = 4'hA; out_ready = 1'b0;

        // Reset held two cycles with request high
        for (int i = 0; i < 2; i++) begin
            tick();
            check("rst_ack", 32'(ack_out), 32'd0);
            check("rst_valid", 32'(out_valid), 32'd0);
            check("rst_level", 32'(fifo_level), 32'd0);
            check("rst_count", 32'(word_count), 32'd0);
            check("rst_data", 32'(out_data), 32'd0);
        end
        exp_q.push_back(4'hA);
        reset = 1'b1;
        tick(); check("rel_ack_e0", 32'(ack_out), 32'd0);
        tick(); check("rel_ack_e1", 32'(ack_out), 32'd0);
        tick(); check("rel_ack_e2", 32'(ack_out), 32'd1);
        check("rel_valid", 32'(out_valid), 32'd1);
        check("rel_data", 32'(out_data), 32'hA);
        check("rel_level", 32'(fifo_level), 32'd1);
        check("rel_count", 32'(word_count), 32'd1);
        req_in = 1'b0;
        tick(); check("rel_ack_fall_e0", 32'(ack_out), 32'd1);
        tick(); check("rel_ack_fall_e1", 32'(ack_out), 32'd1);
        tick(); check("rel_ack_fall_e2", 32'(ack_out), 32'd0);
        drain();

        // Single transfer with exact latency
        exp_q.push_back(4'h1);
        data_in = 4'h1; req_in = 1'b1;
        tick(); check("single_ack_e0", 32'(ack_out), 32'd0);
        tick(); check("single_ack_e1", 32'(ack_out), 32'd0);
        tick(); check("single_ack_e2", 32'(ack_out), 32'd1);
        check("single_state", 32'(dbg_state), 32'd1);
        check("single_valid", 32'(out_valid), 32'd1);
        check("single_data", 32'(out_data), 32'h1);
        check("single_level", 32'(fifo_level), 32'd1);
        req_in = 1'b0;
        tick(); tick(); check("single_ack_hold", 32'(ack_out), 32'd1);
        tick(); check("single_ack_drop", 32'(ack_out), 32'd0);
        drain();

        // Stream with consumer always ready
        pulses0 = ack_pulses;
        out_ready = 1'b1;
        for (int i = 1; i <= 5; i++) send_word(WIDTH'(i));
        tick();
        out_ready = 1'b0;
        check("stream_level", 32'(fifo_level), 32'd0);
        check("stream_q_empty", 32'(exp_q.size()), 32'd0);
        check("stream_pulses", 32'(ack_pulses - pulses0), 32'd5);
        check("stream_count", 32'(word_count), 32'd7);

        // Fill the FIFO, then backpressure the fifth word
        for (int i = 1; i <= 4; i++) send_word(WIDTH'(i));
        check("full_level", 32'(fifo_level), 32'd4);
        exp_q.push_back(4'h5);
        data_in = 4'h5; req_in = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        check("full_stall_ack", 32'(ack_out), 32'd0);
        check("full_stall_state", 32'(dbg_state), 32'd0);
        check("full_stall_level", 32'(fifo_level), 32'd4);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("full_pop_level", 32'(fifo_level), 32'd3);
        check("full_pop_noack", 32'(ack_out), 32'd0);
        tick();
        check("full_accept_ack", 32'(ack_out), 32'd1);
        check("full_accept_level", 32'(fifo_level), 32'd4);
        req_in = 1'b0;
        wait_ack(1'b0, "full_ack_low");
        check("full_count", 32'(word_count), 32'd12);
        drain();

        // Push and pop on the same edge
        send_word(4'h7);
        send_word(4'h8);
        check("sim_level_pre", 32'(fifo_level), 32'd2);
        check("sim_head_pre", 32'(out_data), 32'h7);
        exp_q.push_back(4'h9);
        data_in = 4'h9; req_in = 1'b1;
        tick(); tick();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("sim_ack", 32'(ack_out), 32'd1);
        check("sim_level", 32'(fifo_level), 32'd2);
        check("sim_head", 32'(out_data), 32'h8);
        req_in = 1'b0;
        wait_ack(1'b0, "sim_ack_low");
        check("sim_count", 32'(word_count), 32'd15);
        drain();

        // Reset while the handshake is in ACKED
        data_in = 4'h3; req_in = 1'b1;
        wait_ack(1'b1, "midrst_ack_high");
        check("midrst_state_pre", 32'(dbg_state), 32'd1);
        reset = 1'b0;
        exp_q.delete();
        tick();
        check("midrst_ack", 32'(ack_out), 32'd0);
        check("midrst_level", 32'(fifo_level), 32'd0);
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_count", 32'(word_count), 32'd0);
        req_in = 1'b0;
        tick();
        reset = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check("post_rst_ack", 32'(ack_out), 32'd0);
        check("post_rst_state", 32'(dbg_state), 32'd0);
        check("post_rst_level", 32'(fifo_level), 32'd0);
        check("post_rst_count", 32'(word_count), 32'd0);

        // Word counter wrap
        out_ready = 1'b1;
        for (int i = 0; i < 255; i++) send_word(WIDTH'(i));
        check("wrap_count_max", 32'(word_count), 32'd255);
        send_word(4'hF);
        check("wrap_count_zero", 32'(word_count), 32'd0);
        drain();
        check("final_q_empty", 32'(exp_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/handshake_rx_sink.md
Name: handshake_rx_sink

Overview:
- Downstream consumer of asynchronous_pipeline.
- Takes the pipeline's request_out/data_out, runs a four-phase bundled-data handshake, and returns ack_in.
- Synchronizes the request into the clk domain and buffers captured words in a small FIFO.
- Presents the words on a synchronous valid/ready interface to clocked logic.

Parameters:
- WIDTH, 4, data word width (matches pipeline data_out).
- DEPTH, 4, FIFO entries (power of 2, >=2).
- SYNC_STAGES, 2, flops in the request synchronizer (>=2).
- CNT_W, 8, width of the accepted-word counter.

Ports:
- clk  input  1  system clock, all state on rising edge.
- reset  input  1  synchronous, active-low; sampled on rising clk.
- req_in  input  1  four-phase request from pipeline request_out (asynchronous to clk).
- data_in  input  WIDTH  bundled data from pipeline data_out; stable while req_in high.
- ack_out  output  1  four-phase acknowledge to pipeline ack_in.
- out_data  output  WIDTH  FIFO head word.
- out_valid  output  1  FIFO non-empty.
- out_ready  input  1  consumer accepts out_data this cycle.
- fifo_level  output  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- word_count  output  CNT_W  total words accepted since reset, wraps modulo 2^CNT_W.

Behaviour:
- Reset (reset==0 at clk edge):
  - ack_out=0, out_valid=0, out_data=0, fifo_level=0, word_count=0.
  - FSM=IDLE, synchronizer flops=0, FIFO pointers=0.
  - Reset mid-handshake drops ack_out on that edge. Any in-flight word not yet written is lost. The pipeline is reset alongside.
- Synchronizer:
  - req_s = req_in delayed through SYNC_STAGES flops.
  - data_in is never synchronized; bundled-data timing guarantees stability by the time req_s is high.
- FSM (2 states):
  - IDLE (ack_out=0): if req_s==1 and fifo_level<DEPTH, then on that edge write data_in at wr_ptr, wr_ptr++, word_count++, ack_out<=1, go ACKED. If full, stay in IDLE with ack_out=0 (backpressure stalls the pipeline).
  - ACKED (ack_out=1): if req_s==0, ack_out<=0 and go IDLE. Otherwise hold.
  - Exactly one write per full four-phase cycle.
- Latency:
  - req_in rising before edge k gives req_s=1 after edge k+SYNC_STAGES-1.
  - Write and ack_out=1 occur at edge k+SYNC_STAGES.
  - out_valid is 1 the cycle after the write (registered level).
  - req_in falling clears ack_out SYNC_STAGES edges later.
- FIFO:
  - out_valid = (fifo_level!=0).
  - out_data = mem[rd_ptr], and equals 0 when empty.
  - Pop on out_valid && out_ready: rd_ptr++.
  - Pointers are log2(DEPTH) bits and wrap naturally.
  - Simultaneous push and pop: level unchanged, both pointers advance.
  - The full check uses the level before the pop; a pop in the same cycle does not enable a push (one-cycle conservative stall).
  - out_ready while empty: no effect.
- Width rules: word_count wraps 2^CNT_W-1 -> 0 with no flag. fifo_level never exceeds DEPTH.
- Protocol robustness:
  - req_in glitches shorter than one clk may be missed; this is legal since the pipeline holds req until ack.
  - req_s falling while in IDLE is ignored.

Test Plan:
- Reset: hold reset=0 for 2 cycles with req_in=1 -> ack_out=0, out_valid=0, fifo_level=0, word_count=0 throughout. Release -> first write at 2nd edge after release.
- Single transfer: req_in=1, data_in=4'h1, out_ready=0 -> ack_out=1 at edge 2. Next cycle out_valid=1, out_data=1, fifo_level=1. Then req_in=0 -> ack_out=0 two edges later.
- Stream 1,2,3,4,5 with out_ready=1 -> out_data sequence 1,2,3,4,5 in order, word_count=5, fifo_level returns to 0, exactly 5 ack pulses.
- Full/backpressure: out_ready=0, send 1..5 with DEPTH=4 -> after 4 words fifo_level=4 and the 5th req stays unacked (ack_out=0). Pulse out_ready 1 cycle -> pops 1, level 3, then word 5 accepted, level 4.
- Simultaneous push/pop: level=2 (head 7), out_ready=1 on the write edge of word 9 -> level stays 2, next head 8 (prior second entry), 9 at tail.
- Reset mid-handshake: assert reset=0 while in ACKED -> ack_out=0 next edge, FIFO empty, word_count=0. After release with req_in low -> FSM idle, no spurious write.
